// File: rtl/nios2_mult_sequencer.sv
// Sequences a 16x16 three-partial-product multiplier cell to execute 32x32 multiply ops.
// Define MULT_SEQ_HI_EN to add the high-word ops (MULXUU/MULXSU/MULXSS); otherwise they return rsp_err.
module nios2_mult_sequencer #(
    parameter int MULT_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] mc_src1,
    output logic [31:0] mc_src2,
    output logic        mc_en,
    input  logic [31:0] mc_p1,
    input  logic [31:0] mc_p2,
    input  logic [31:0] mc_p3
);

`ifdef MULT_SEQ_HI_EN
    typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESULT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, RESULT, DONE} state_t;
`endif

    localparam logic [1:0] CNT_LOAD = 2'(MULT_LATENCY - 1);

    state_t      state;
    logic [1:0]  cnt_q;
    logic [1:0]  op_p0;
    logic [48:0] lo64_p1;
    logic [31:0] result_w;
    logic        err_w;
    logic        accept;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && req_valid;

    // Low 49 bits of the full product from the three low-half partial products.
    function automatic logic [48:0] combine_lo(input logic [31:0] p1, input logic [31:0] p2,
                                               input logic [31:0] p3);
        logic [32:0] mid;
        mid = {1'b0, p2} + {1'b0, p3};
        return {17'b0, p1} + {mid, 16'b0};
    endfunction

`ifdef MULT_SEQ_HI_EN
    logic [31:0] a_p0;
    logic [31:0] b_p0;
    logic [31:0] hh_p2;

    // Unsigned high word, then two's-complement corrections for signed operands.
    function automatic logic [31:0] high_word(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hh,
                                              input logic [16:0] carry);
        logic [31:0] w;
        w = hh + {15'b0, carry};
        if (op[1] && a[31])
            w = w - b;
        if ((op == 2'b11) && b[31])
            w = w - a;
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0  <= req_a;
            b_p0  <= req_b;
            op_p0 <= req_op;
        end
        if ((state == WAIT_LO) && (cnt_q == 2'd0))
            lo64_p1 <= combine_lo(mc_p1, mc_p2, mc_p3);
        if ((state == WAIT_HI) && (cnt_q == 2'd0))
            hh_p2 <= mc_p1;
    end

    always_comb begin
        err_w    = 1'b0;
        result_w = lo64_p1[31:0];
        if (op_p0 != 2'b00)
            result_w = high_word(op_p0, a_p0, b_p0, hh_p2, lo64_p1[48:32]);
    end
`else
    logic unused_hi_bits;

    always_ff @(posedge clk) begin
        if (accept)
            op_p0 <= req_op;
        if ((state == WAIT_LO) && (cnt_q == 2'd0))
            lo64_p1 <= combine_lo(mc_p1, mc_p2, mc_p3);
    end

    // Upper product bits only feed the high-word path, which this build lacks.
    assign unused_hi_bits = ^lo64_p1[48:32];

    always_comb begin
        err_w    = (op_p0 != 2'b00);
        result_w = err_w ? 32'd0 : lo64_p1[31:0];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt_q     <= 2'd0;
            mc_en     <= 1'b0;
            mc_src1   <= 32'd0;
            mc_src2   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mc_en   <= 1'b1;
                        mc_src1 <= req_a;
                        mc_src2 <= req_b;
                        state   <= ISSUE_LO;
                    end
                end
                ISSUE_LO: begin
                    mc_en <= 1'b0;
                    cnt_q <= CNT_LOAD;
                    state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
`ifdef MULT_SEQ_HI_EN
                        if (op_p0 == 2'b00) begin
                            state <= RESULT;
                        end else begin
                            mc_en   <= 1'b1;
                            mc_src1 <= {16'b0, a_p0[31:16]};
                            mc_src2 <= {16'b0, b_p0[31:16]};
                            state   <= ISSUE_HI;
                        end
`else
                        state <= RESULT;
`endif
                    end
                end
`ifdef MULT_SEQ_HI_EN
                ISSUE_HI: begin
                    mc_en <= 1'b0;
                    cnt_q <= CNT_LOAD;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (cnt_q != 2'd0)
                        cnt_q <= cnt_q - 2'd1;
                    else
                        state <= RESULT;
                end
`endif
                RESULT: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= result_w;
                    rsp_err   <= err_w;
                    state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_mult_sequencer.sv
// Bench for nios2_mult_sequencer: instance 0 at MULT_LATENCY=1, instance 1 at MULT_LATENCY=3,
// each driven by its own behavioural multiplier cell. Honors MULT_SEQ_HI_EN like the design.
module tb_nios2_mult_sequencer;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_op    [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic        busy      [2];
    logic [31:0] mc_src1   [2];
    logic [31:0] mc_src2   [2];
    logic        mc_en     [2];
    logic [31:0] mc_p1     [2];
    logic [31:0] mc_p2     [2];
    logic [31:0] mc_p3     [2];

    nios2_mult_sequencer #(.MULT_LATENCY(LAT0)) u0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_a(req_a[0]), .req_b(req_b[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]),
        .mc_src1(mc_src1[0]), .mc_src2(mc_src2[0]), .mc_en(mc_en[0]),
        .mc_p1(mc_p1[0]), .mc_p2(mc_p2[0]), .mc_p3(mc_p3[0])
    );

    nios2_mult_sequencer #(.MULT_LATENCY(LAT1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_a(req_a[1]), .req_b(req_b[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]),
        .mc_src1(mc_src1[1]), .mc_src2(mc_src2[1]), .mc_en(mc_en[1]),
        .mc_p1(mc_p1[1]), .mc_p2(mc_p2[1]), .mc_p3(mc_p3[1])
    );

    // Multiplier cell: operands captured on an enabled edge, products LAT edges later.
    function automatic logic [95:0] cell_prod(input logic [31:0] s1, input logic [31:0] s2);
        logic [31:0] p1, p2, p3;
        p1 = {16'b0, s1[15:0]}  * {16'b0, s2[15:0]};
        p2 = {16'b0, s1[15:0]}  * {16'b0, s2[31:16]};
        p3 = {16'b0, s1[31:16]} * {16'b0, s2[15:0]};
        return {p1, p2, p3};
    endfunction

    logic [95:0] cell0 [4];
    logic [95:0] cell1 [4];
    always @(posedge clk) begin
        if (mc_en[0]) cell0[0] <= cell_prod(mc_src1[0], mc_src2[0]);
        if (mc_en[1]) cell1[0] <= cell_prod(mc_src1[1], mc_src2[1]);
        for (int k = 1; k < 4; k++) begin
            cell0[k] <= cell0[k-1];
            cell1[k] <= cell1[k-1];
        end
    end
    assign {mc_p1[0], mc_p2[0], mc_p3[0]} = cell0[LAT0-1];
    assign {mc_p1[1], mc_p2[1], mc_p3[1]} = cell1[LAT1-1];

    int en_cnt0 = 0;
    always @(posedge clk) if (mc_en[0]) en_cnt0 <= en_cnt0 + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // 64-bit reference: sign-extend per op, multiply, pick the word.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = {32'b0, a};
        be = {32'b0, b};
        if (op[1]) ae = {{32{a[31]}}, a};
        if (op == 2'b11) be = {{32{b[31]}}, b};
        p = ae * be;
        if (op == 2'b00) return p[31:0];
`ifdef MULT_SEQ_HI_EN
        return p[63:32];
`else
        return 32'd0;
`endif
    endfunction

    task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output bit ok);
        int n;
        n  = 0;
        ok = 0;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_a[i]     = a;
        req_b[i]     = b;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            req_valid[i] = 1'b0;
            total++;
            bad++;
            $display("FAIL accept_timeout inst%0d: req_ready=0 expected 1", i);
            return;
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        ok = 1;
    endtask

    task automatic handshake(input int i);
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[i] = 1'b0;
    endtask

    // Latency = rising edges after the accept edge until rsp_valid is seen.
    task automatic collect(input int i, input bit hold, output logic [31:0] d, output logic e,
                           output int lat, output bit ok);
        ok  = 0;
        lat = 0;
        d   = 32'd0;
        e   = 1'b0;
        @(negedge clk);
        while (!rsp_valid[i] && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!rsp_valid[i]) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout inst%0d: rsp_valid=0 expected 1", i);
            return;
        end
        d  = rsp_data[i];
        e  = rsp_err[i];
        ok = 1;
        if (!hold) handshake(i);
    endtask

    task automatic check_reset_outputs(input string nm, input int i);
        check({nm, "_ctl"}, {27'b0, rsp_valid[i], rsp_err[i], busy[i], mc_en[i], req_ready[i]},
              32'h1);
        check({nm, "_data"}, rsp_data[i], 32'd0);
        check({nm, "_src1"}, mc_src1[i], 32'd0);
        check({nm, "_src2"}, mc_src2[i], 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        e;
        int          lat;
        int          en;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] d;
        logic        e;
        int          lat;
        int          en0;
        int          seen;
        bit          ok;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] held;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_op[i]    = 2'b00;
            req_a[i]     = 32'd0;
            req_b[i]     = 32'd0;
            rsp_ready[i] = 1'b0;
        end

        vecs.push_back('{2'd0, 32'h00010003, 32'h00020005, 32'h000B000F, 1'b0, 3, 1});
        vecs.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3, 1});
        vecs.push_back('{2'd0, 32'h00000005, 32'h00000007, 32'h00000023, 1'b0, 3, 1});
        vecs.push_back('{2'd0, 32'h80000000, 32'h00000003, 32'h80000000, 1'b0, 3, 1});
`ifdef MULT_SEQ_HI_EN
        vecs.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5, 2});
        vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 2});
        vecs.push_back('{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 5, 2});
        vecs.push_back('{2'd1, 32'h00010003, 32'h00020005, 32'h00000002, 1'b0, 5, 2});
        vecs.push_back('{2'd3, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 5, 2});
        vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 5, 2});
        vecs.push_back('{2'd3, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 5, 2});
`else
        vecs.push_back('{2'd1, 32'h00000005, 32'h00000007, 32'h00000000, 1'b1, 3, 1});
        vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3, 1});
        vecs.push_back('{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3, 1});
`endif

        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("reset0", 0);
        check_reset_outputs("reset1", 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed table at MULT_LATENCY=1
        foreach (vecs[k]) begin
            en0 = en_cnt0;
            issue(0, vecs[k].op, vecs[k].a, vecs[k].b, ok);
            if (ok) begin
                collect(0, 1'b0, d, e, lat, ok);
                if (ok) begin
                    check($sformatf("vec%0d_data", k), d, vecs[k].d);
                    check($sformatf("vec%0d_err", k), {31'b0, e}, {31'b0, vecs[k].e});
                    check($sformatf("vec%0d_lat", k), 32'(lat), 32'(vecs[k].lat));
                    check($sformatf("vec%0d_en_pulses", k), 32'(en_cnt0 - en0), 32'(vecs[k].en));
                end
            end
        end

        // Consumer stalls for 10 cycles
        issue(0, 2'd0, 32'h00001234, 32'h00000010, ok);
        if (ok) begin
            collect(0, 1'b1, held, e, lat, ok);
            if (ok) begin
                check("hold_data", held, 32'h00012340);
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check($sformatf("hold%0d_ctl", c),
                          {29'b0, rsp_valid[0], req_ready[0], mc_en[0]}, 32'h4);
                    check($sformatf("hold%0d_data", c), rsp_data[0], held);
                end
                handshake(0);
                @(negedge clk);
                check("post_hs_ready", {30'b0, req_ready[0], rsp_valid[0]}, 32'h2);
            end
        end

        // Reset during WAIT_LO on the latency-3 instance
        issue(1, 2'd0, 32'h00000005, 32'h00000007, ok);
        if (ok) begin
            repeat (2) @(posedge clk);
            #2;
            check("abort_lo_busy", {31'b0, busy[1]}, 32'h1);
            reset_n = 1'b0;
            #1;
            check_reset_outputs("abort_lo", 1);
            @(negedge clk);
            reset_n = 1'b1;
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (rsp_valid[1]) seen++;
            end
            check("abort_lo_no_rsp", 32'(seen), 32'd0);
        end
        issue(1, 2'd0, 32'h00010003, 32'h00020005, ok);
        if (ok) begin
            collect(1, 1'b0, d, e, lat, ok);
            if (ok) begin
                check("after_abort_lo_data", d, 32'h000B000F);
                check("after_abort_lo_lat", 32'(lat), 32'd5);
            end
        end

`ifdef MULT_SEQ_HI_EN
        // Reset during WAIT_HI on the latency-3 instance
        issue(1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, ok);
        if (ok) begin
            repeat (6) @(posedge clk);
            #2;
            check("abort_hi_src1", mc_src1[1], 32'h0000FFFF);
            reset_n = 1'b0;
            #1;
            check_reset_outputs("abort_hi", 1);
            @(negedge clk);
            reset_n = 1'b1;
            seen = 0;
            repeat (14) begin
                @(negedge clk);
                if (rsp_valid[1]) seen++;
            end
            check("abort_hi_no_rsp", 32'(seen), 32'd0);
        end
        issue(1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, ok);
        if (ok) begin
            collect(1, 1'b0, d, e, lat, ok);
            if (ok) begin
                check("after_abort_hi_data", d, 32'h00000000);
                check("after_abort_hi_lat", 32'(lat), 32'd9);
            end
        end
`endif

        // Random ops at MULT_LATENCY=3 against the 64-bit reference
        for (int k = 0; k < 1000; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ((k % 16) == 0) a = 32'h80000000;
            if ((k % 23) == 0) b = 32'hFFFFFFFF;
            issue(1, op, a, b, ok);
            if (!ok) break;
            collect(1, 1'b0, d, e, lat, ok);
            if (!ok) break;
            check($sformatf("rnd%0d_data op=%0d a=%h b=%h", k, op, a, b), d, ref_result(op, a, b));
`ifdef MULT_SEQ_HI_EN
            check($sformatf("rnd%0d_err", k), {31'b0, e}, 32'h0);
            check($sformatf("rnd%0d_lat", k), 32'(lat), (op == 2'd0) ? 32'd5 : 32'd9);
`else
            check($sformatf("rnd%0d_err", k), {31'b0, e}, (op == 2'd0) ? 32'h0 : 32'h1);
            check($sformatf("rnd%0d_lat", k), 32'(lat), 32'd5);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
